// File: rtl/div_unit.sv
// Execute-stage front end for RISC-V DIV/DIVU/REM/REMU.
// Resolves divide-by-zero and signed overflow locally; everything else goes to the external divider.
module div_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        div_start,
  output logic        div_sign,
  output logic [31:0] div_divident,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_busy
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q;
  logic        rem_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;

  logic        accept;
  logic        div_by_zero;
  logic        overflow;
  logic        special;
  logic [31:0] special_data;

  always_comb begin
    req_ready    = (state_q == StIdle) && !div_busy && !flush;
    accept       = req_valid && req_ready;
    div_by_zero  = (req_rs2 == 32'h0000_0000);
    overflow     = !req_op[0] && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
    special      = div_by_zero || overflow;
    special_data = 32'h0000_0000;
    if (div_by_zero) begin
      special_data = req_op[1] ? req_rs1 : 32'hFFFF_FFFF;
    end else if (overflow) begin
      special_data = req_op[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  // Gated by reset_n so a request held across reset never launches the divider.
  assign div_start    = accept && !special && reset_n;
  assign div_sign     = !req_op[0];
  assign div_divident = req_rs1;
  assign div_divisor  = req_rs2;

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      rem_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0000_0000;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            rem_q <= req_op[1];
            if (special) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= special_data;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          // Flush beats capture; an abandoned divide finishes silently in the divider.
          if (flush) begin
            state_q <= StIdle;
          end else if (!div_busy) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= rem_q ? div_remainder : div_quotient;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit with a behavioural 32-cycle divider that caches its last operands.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        div_start;
  logic        div_sign;
  logic [31:0] div_divident;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_busy;

  div_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_ready    (req_ready),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .div_start    (div_start),
    .div_sign     (div_sign),
    .div_divident (div_divident),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_busy     (div_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endfunction

  // Divider model: busy in the 32 cycles after start, results registered when busy falls.
  logic [31:0] m_a, m_b;
  logic        m_sign, m_valid;
  int          m_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_busy      <= 1'b0;
      m_valid       <= 1'b0;
      m_cnt         <= 0;
      m_a           <= '0;
      m_b           <= '0;
      m_sign        <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else if (div_busy) begin
      if (m_cnt == 0) begin
        div_busy <= 1'b0;
        m_valid  <= 1'b1;
        if (m_sign) begin
          div_quotient  <= 32'($signed(m_a) / $signed(m_b));
          div_remainder <= 32'($signed(m_a) % $signed(m_b));
        end else begin
          div_quotient  <= m_a / m_b;
          div_remainder <= m_a % m_b;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (div_start && !(m_valid && div_divident == m_a && div_divisor == m_b
                                && div_sign == m_sign)) begin
      m_a      <= div_divident;
      m_b      <= div_divisor;
      m_sign   <= div_sign;
      m_valid  <= 1'b0;
      div_busy <= 1'b1;
      m_cnt    <= 31;
    end
  end

  typedef struct {
    logic [31:0] data;
    int          at;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clk) begin
    if (reset_n && resp_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: got resp_valid=1 data %h at cycle %0d, required none",
                 resp_data, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_data"}, resp_data, e.data);
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
      end
    end
  end

  // Drives one request from a negedge, waits (bounded) for req_ready, checks launch signals.
  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input logic exp_start, input bit push, output int acc_cyc);
    int tries = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    #1;
    while (!req_ready && tries < 100) begin
      @(negedge clk);
      #1;
      tries++;
    end
    acc_cyc = cyc;
    if (!req_ready) begin
      n_checks++;
      $display("FAIL %s_accept: got req_ready=0 after 100 cycles, required 1", name);
    end else begin
      check({name, "_start"}, 32'(div_start), 32'(exp_start));
      check({name, "_sign"}, 32'(div_sign), 32'(!op[0]));
      if (push) sb_q.push_back('{data: exp, at: cyc + lat, name: name});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d responses outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  int t0, acc;

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_rs1   = 32'd100;
    req_rs2   = 32'd7;
    repeat (2) @(negedge clk);
    #1;
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_data", resp_data, 32'h0);
    check("reset_div_start", 32'(div_start), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34, 1'b1, 1'b1, acc);
    drain("divu_100_7");
    #1;
    check("resp_data_hold", resp_data, 32'd14);
    issue("remu_hit", 2'b11, 32'd100, 32'd7, 32'd2, 2, 1'b1, 1'b1, acc);
    drain("remu_hit");

    issue("div_neg", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 1'b1, 1'b1, acc);
    drain("div_neg");
    issue("rem_neg_hit", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 2, 1'b1, 1'b1, acc);
    drain("rem_neg_hit");

    issue("div_by0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, 1'b1, acc);
    issue("remu_by0", 2'b11, 32'd5, 32'd0, 32'd5, 1, 1'b0, 1'b1, acc);
    drain("by0");

    issue("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 1'b1, acc);
    issue("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, 1'b1, acc);
    drain("ovf");

    // Flush in IDLE blocks a coincident request.
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_rs1   = 32'd8;
    req_rs2   = 32'd2;
    #1;
    check("idle_flush_ready", 32'(req_ready), 32'd0);
    check("idle_flush_start", 32'(div_start), 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;

    issue("divu_flushed", 2'b01, 32'd1000, 32'd3, 32'd0, 0, 1'b1, 1'b0, t0);
    while (cyc < t0 + 10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    while (cyc < t0 + 32) begin
      @(negedge clk);
      #1;
      check("flush_ready_low", 32'(req_ready), 32'd0);
    end
    issue("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 34, 1'b1, 1'b1, acc);
    check("post_flush_accept_cycle", 32'(acc), 32'(t0 + 33));
    drain("divu_9_3");

    issue("divu_reset", 2'b01, 32'd50, 32'd5, 32'd0, 0, 1'b1, 1'b0, acc);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midwait_reset_valid", 32'(resp_valid), 32'd0);
    check("midwait_reset_data", resp_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (45) @(negedge clk);
    check("final_outstanding", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Execute-stage front end for the RISC-V M-extension divide/remainder instructions (DIV, DIVU, REM, REMU). It accepts one operation from the execute stage and resolves divide-by-zero and signed overflow itself in one cycle. All other operations are launched on the 32-cycle restoring divider. The block waits for that divider, selects quotient or remainder, and returns a registered result with a one-cycle valid pulse.

## Interface

Parameters: none (XLEN fixed at 32).

- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  execute stage presents a divide op
- req_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_rs1  in  32  dividend
- req_rs2  in  32  divisor
- req_ready  out  1  op accepted this cycle when req_valid && req_ready
- flush  in  1  kill any in-flight op; no response is produced for it
- resp_valid  out  1  one-cycle pulse; resp_data valid
- resp_data  out  32  result; holds the last value until the next pulse
- div_start  out  1  launch divider
- div_sign  out  1  signed divide (1 for DIV/REM)
- div_divident  out  32  dividend to divider
- div_divisor  out  32  divisor to divider
- div_quotient  in  32  divider quotient (registered in divider)
- div_remainder  in  32  divider remainder (registered in divider)
- div_busy  in  1  divider iterating; rises the cycle after div_start and lasts 32 cycles

## Operation

- The FSM has two states, IDLE and WAIT. State, op and resp_* are flops.
- req_ready = (state==IDLE) && !div_busy && !flush.
- Accept (req_valid && req_ready): latch req_op. Then classify the op:
  - Divide by zero (rs2==0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (op DIV or REM, rs1==0x80000000, rs2==0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Special case: resp_data is loaded and resp_valid is pulsed at the accept edge. State stays IDLE, and div_start stays 0.
  - Otherwise: the accept edge moves the FSM to WAIT.
- Divider launch:
  - div_start = accept && !special.
  - div_sign = !req_op[0].
  - div_divident and div_divisor are req_rs1 and req_rs2 passed straight through.
- Divider cache hit: if the divider already holds the same operands and sign, it does not start. div_busy stays 0 and its outputs already hold the result. The block treats this exactly like a completed divide.
- In WAIT:
  - When div_busy==0, capture the result: resp_data = op[1] ? div_remainder : div_quotient. Pulse resp_valid and return to IDLE.
  - When div_busy==1, stay in WAIT.
- Flush:
  - In WAIT, go to IDLE with no capture and no pulse. Flush wins over capture in the same cycle.
  - In IDLE, a coincident req_valid is not accepted.
  - An abandoned divide runs to completion in the divider. req_ready stays low until div_busy falls.
- The divider's own sign correction is not relied upon for the special cases above.

## Timing

- Reset (async assert): state IDLE, resp_valid 0, resp_data 0. While reset_n is low, div_start is 0.
- Latency, with the accept edge at the end of cycle T:
  - Special case: resp_valid high in cycle T+1.
  - Divider cache hit: WAIT in T+1 sees div_busy 0, so resp_valid is high in T+2.
  - Normal divide: div_busy is high in T+1..T+32 and low in T+33, so resp_valid is high in T+34.
- resp_valid is exactly one cycle per non-flushed op.
- Back-to-back: req_ready may be high in the same cycle resp_valid is high, since the state is already IDLE.
- Reset mid-WAIT returns the block to IDLE immediately. No response is produced after reset.

## Test plan

- DIVU rs1=100, rs2=7 -> div_start 1 at accept, div_sign 0; resp_valid at T+34 with resp_data 14. Then REMU 100,7 -> cache hit; resp_valid at T+2 with resp_data 2.
- DIV rs1=0xFFFFFF9C (-100), rs2=7 -> resp_data 0xFFFFFFF2 (-14). REM with the same operands -> 0xFFFFFFFE (-2).
- DIV rs1=5, rs2=0 -> no div_start; resp_valid at T+1 with resp_data 0xFFFFFFFF. REMU rs1=5, rs2=0 -> resp_data 5.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> resp_data 0x80000000 at T+1. REM with the same operands -> 0.
- DIVU 1000/3, flush at T+10 -> no resp_valid. req_ready stays low until T+33. A new DIVU 9/3 accepted at T+33 -> resp_data 3.
- reset_n pulsed low during WAIT -> resp_valid and resp_data are 0 immediately. No pulse follows after release.
